// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Purpose:
//   One-hot multicycle controller for the 54-instruction CPU. Each instruction
//   is sequenced through IF -> ID -> EX and then, depending on its class, an
//   optional mul/div wait (MD), a data memory access (MEM) and a register
//   write-back (WB). Instruction-memory, data-memory and mul/div handshakes
//   can stretch IF, MEM and MD respectively by any number of cycles.
//
// Optional feature:
//   CTRL_PERF_EN - when defined, cycle_cnt_o counts every cycle out of reset
//                  and retire_cnt_o counts every instr_done_o cycle (both wrap
//                  modulo 2^CNT_W). When undefined both ports read 0 and no
//                  counter flops are built.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset; also gates every output
//   decoded_instr_i  one-hot decoded instruction, sampled in ID
//   imem_ready_i     instruction word valid (consumed in IF)
//   dmem_ready_i     data access complete (consumed in MEM)
//   md_done_i        mul/div result valid (consumed in MD)
//   branch_taken_i   branch condition (consumed in EX)
//   state_o          one-hot state {WB,MEM,MD,EX,ID,IF}
//   ir_in_o .. regfile_w_o  datapath strobes
//   rf_wsel_o        write-back source: 0 ALU Z, 1 memory, 2 mul/div
//   instr_done_o     last cycle of an instruction
//   cycle_cnt_o      performance counter: cycles out of reset
//   retire_cnt_o     performance counter: retired instructions
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int unsigned        INSTR_W     = 54,
  parameter logic [INSTR_W-1:0] WB_MASK     = 54'h0_0000_FFFF_FFFF,
  parameter logic [INSTR_W-1:0] LOAD_MASK   = 54'h0_001F_0000_0000,
  parameter logic [INSTR_W-1:0] STORE_MASK  = 54'h0_00E0_0000_0000,
  parameter logic [INSTR_W-1:0] BRANCH_MASK = 54'h0_FF00_0000_0000,
  parameter logic [INSTR_W-1:0] MULDIV_MASK = 54'hF_0000_0000_0000,
  parameter int unsigned        CNT_W       = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [INSTR_W-1:0] decoded_instr_i,
  input  logic               imem_ready_i,
  input  logic               dmem_ready_i,
  input  logic               md_done_i,
  input  logic               branch_taken_i,
  output logic [5:0]         state_o,
  output logic               ir_in_o,
  output logic               pc_ena_o,
  output logic               pc_sel_o,
  output logic               decode_ena_o,
  output logic               zin_o,
  output logic               zout_o,
  output logic               md_start_o,
  output logic               dmem_rd_o,
  output logic               dmem_wr_o,
  output logic               regfile_w_o,
  output logic [1:0]         rf_wsel_o,
  output logic               instr_done_o,
  output logic [CNT_W-1:0]   cycle_cnt_o,
  output logic [CNT_W-1:0]   retire_cnt_o
);

  // One-hot encoding: bit order matches state_o = {WB,MEM,MD,EX,ID,IF}.
  typedef enum logic [5:0] {
    ST_IF  = 6'b000001,
    ST_ID  = 6'b000010,
    ST_EX  = 6'b000100,
    ST_MD  = 6'b001000,
    ST_MEM = 6'b010000,
    ST_WB  = 6'b100000
  } state_e;

  typedef enum logic [2:0] {
    CL_NOP    = 3'd0,
    CL_WB     = 3'd1,
    CL_BRANCH = 3'd2,
    CL_MULDIV = 3'd3,
    CL_STORE  = 3'd4,
    CL_LOAD   = 3'd5
  } class_e;

  state_e state_q, state_d;
  class_e class_q, class_d;

  // Raw (ungated) strobes, produced by the next-state process.
  logic       ir_in_s;
  logic       pc_ena_s;
  logic       pc_sel_s;
  logic       decode_ena_s;
  logic       zin_s;
  logic       zout_s;
  logic       md_start_s;
  logic       dmem_rd_s;
  logic       dmem_wr_s;
  logic       regfile_w_s;
  logic [1:0] rf_wsel_s;
  logic       instr_done_s;

  // Write-back source derived from the latched class.
  logic [1:0] wb_src;

  // ---------------------------------------------------------------------------
  // Instruction classification. Several class bits may be set at once on a
  // malformed decode; the fixed priority below resolves that deterministically.
  // ---------------------------------------------------------------------------
  always_comb begin
    class_d = CL_NOP;
    if (|(decoded_instr_i & LOAD_MASK)) begin
      class_d = CL_LOAD;
    end else if (|(decoded_instr_i & STORE_MASK)) begin
      class_d = CL_STORE;
    end else if (|(decoded_instr_i & MULDIV_MASK)) begin
      class_d = CL_MULDIV;
    end else if (|(decoded_instr_i & BRANCH_MASK)) begin
      class_d = CL_BRANCH;
    end else if (|(decoded_instr_i & WB_MASK)) begin
      class_d = CL_WB;
    end
  end

  always_comb begin
    wb_src = 2'd0;
    if (class_q == CL_LOAD) begin
      wb_src = 2'd1;
    end else if (class_q == CL_MULDIV) begin
      wb_src = 2'd2;
    end
  end

  // ---------------------------------------------------------------------------
  // State and class registers. The class is captured only on the ID->EX edge
  // so later decoder activity cannot disturb an instruction in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IF;
      class_q <= CL_NOP;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ID) begin
        class_q <= class_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and strobe decode.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    ir_in_s      = 1'b0;
    pc_ena_s     = 1'b0;
    pc_sel_s     = 1'b0;
    decode_ena_s = 1'b0;
    zin_s        = 1'b0;
    zout_s       = 1'b0;
    md_start_s   = 1'b0;
    dmem_rd_s    = 1'b0;
    dmem_wr_s    = 1'b0;
    regfile_w_s  = 1'b0;
    rf_wsel_s    = 2'd0;
    instr_done_s = 1'b0;

    case (state_q)
      ST_IF: begin
        // Waiting in IF for the instruction word is silent.
        if (imem_ready_i) begin
          ir_in_s  = 1'b1;
          pc_ena_s = 1'b1;
          state_d  = ST_ID;
        end
      end

      ST_ID: begin
        decode_ena_s = 1'b1;
        state_d      = ST_EX;
      end

      ST_EX: begin
        zin_s = 1'b1;
        case (class_q)
          CL_MULDIV: begin
            md_start_s = 1'b1;
            state_d    = ST_MD;
          end
          CL_LOAD, CL_STORE: begin
            state_d = ST_MEM;
          end
          CL_WB: begin
            state_d = ST_WB;
          end
          CL_BRANCH: begin
            // Taken branch loads the target through the PC mux (pc_sel=1).
            if (branch_taken_i) begin
              pc_ena_s = 1'b1;
              pc_sel_s = 1'b1;
            end
            state_d      = ST_IF;
            instr_done_s = 1'b1;
          end
          default: begin
            state_d      = ST_IF;
            instr_done_s = 1'b1;
          end
        endcase
      end

      ST_MD: begin
        if (md_done_i) begin
          state_d = ST_WB;
        end
      end

      ST_MEM: begin
        zout_s    = 1'b1;
        dmem_rd_s = (class_q == CL_LOAD);
        dmem_wr_s = (class_q != CL_LOAD);
        if (dmem_ready_i) begin
          if (class_q == CL_LOAD) begin
            state_d = ST_WB;
          end else begin
            state_d      = ST_IF;
            instr_done_s = 1'b1;
          end
        end
      end

      ST_WB: begin
        regfile_w_s  = 1'b1;
        rf_wsel_s    = wb_src;
        // Only the ALU path drives the result bus from Z during write-back.
        zout_s       = (wb_src == 2'd0);
        state_d      = ST_IF;
        instr_done_s = 1'b1;
      end

      default: begin
        // Illegal one-hot pattern: recover to fetch without side effects.
        state_d = ST_IF;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Every strobe is gated by rst_ni so that an asynchronous reset
  // silences the datapath immediately, even between clock edges.
  // ---------------------------------------------------------------------------
  assign state_o      = state_q;
  assign ir_in_o      = ir_in_s      & rst_ni;
  assign pc_ena_o     = pc_ena_s     & rst_ni;
  assign pc_sel_o     = pc_sel_s     & rst_ni;
  assign decode_ena_o = decode_ena_s & rst_ni;
  assign zin_o        = zin_s        & rst_ni;
  assign zout_o       = zout_s       & rst_ni;
  assign md_start_o   = md_start_s   & rst_ni;
  assign dmem_rd_o    = dmem_rd_s    & rst_ni;
  assign dmem_wr_o    = dmem_wr_s    & rst_ni;
  assign regfile_w_o  = regfile_w_s  & rst_ni;
  assign rf_wsel_o    = rf_wsel_s    & {2{rst_ni}};
  assign instr_done_o = instr_done_s & rst_ni;

  // ---------------------------------------------------------------------------
  // Performance counters.
  // ---------------------------------------------------------------------------
`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] retire_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (instr_done_s) begin
        retire_cnt_q <= retire_cnt_q + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt_o  = cycle_cnt_q;
  assign retire_cnt_o = retire_cnt_q;
`else
  assign cycle_cnt_o  = '0;
  assign retire_cnt_o = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Randomised scoreboard bench for multicycle_ctrl. The driver issues one
// instruction at a time with chosen handshake stall lengths and pushes the
// expected per-instruction strobe totals (computed from the class rules) into
// a queue. The monitor accumulates what the DUT does each cycle and, on every
// instr_done, pops and compares one expected record.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int CW = 4;

  localparam logic [5:0] S_IF  = 6'b000001;
  localparam logic [5:0] S_ID  = 6'b000010;
  localparam logic [5:0] S_EX  = 6'b000100;
  localparam logic [5:0] S_MD  = 6'b001000;
  localparam logic [5:0] S_MEM = 6'b010000;

  // Class identifiers used by the reference model (priority grows with value).
  localparam int C_NOP = 0, C_WB = 1, C_BR = 2, C_MD = 3, C_ST = 4, C_LD = 5;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [53:0]   decoded_instr = '0;
  logic          imem_ready = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          md_done = 1'b0;
  logic          branch_taken = 1'b0;
  logic [5:0]    state;
  logic          ir_in, pc_ena, pc_sel, decode_ena, zin, zout;
  logic          md_start, dmem_rd, dmem_wr, regfile_w, instr_done;
  logic [1:0]    rf_wsel;
  logic [CW-1:0] cycle_cnt, retire_cnt;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .decoded_instr_i (decoded_instr),
    .imem_ready_i    (imem_ready),
    .dmem_ready_i    (dmem_ready),
    .md_done_i       (md_done),
    .branch_taken_i  (branch_taken),
    .state_o         (state),
    .ir_in_o         (ir_in),
    .pc_ena_o        (pc_ena),
    .pc_sel_o        (pc_sel),
    .decode_ena_o    (decode_ena),
    .zin_o           (zin),
    .zout_o          (zout),
    .md_start_o      (md_start),
    .dmem_rd_o       (dmem_rd),
    .dmem_wr_o       (dmem_wr),
    .regfile_w_o     (regfile_w),
    .rf_wsel_o       (rf_wsel),
    .instr_done_o    (instr_done),
    .cycle_cnt_o     (cycle_cnt),
    .retire_cnt_o    (retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cycles;
    int ir_in;
    int pc_ena;
    int pc_sel;
    int decode;
    int zin;
    int zout;
    int md_start;
    int rd;
    int wr;
    int regw;
    int wsel;
    int wsel_bad;
  } rec_t;

  rec_t exp_q[$];
  rec_t acc;
  rec_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   n_ret    = 0;
  int   tb_cyc   = 0;  // cycles out of reset, counted by the bench
  int   tb_ret   = 0;  // instructions completed since reset, counted by the driver

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) tb_cyc <= 0;
    else         tb_cyc <= tb_cyc + 1;
  end

  // Reference model: strobe totals over one instruction from the class rules.
  function automatic rec_t model(input int cls, input bit taken,
                                 input int iw, input int dw, input int mw);
    rec_t r;
    r = '{default: 0};
    r.cycles = (iw + 1) + 1 + 1;  // IF (with stalls), ID, EX
    r.ir_in  = 1;
    r.pc_ena = 1;
    r.decode = 1;
    r.zin    = 1;
    case (cls)
      C_LD: begin
        r.rd     = dw + 1;
        r.zout   = dw + 1;
        r.regw   = 1;
        r.wsel   = 1;
        r.cycles += (dw + 1) + 1;
      end
      C_ST: begin
        r.wr     = dw + 1;
        r.zout   = dw + 1;
        r.cycles += dw + 1;
      end
      C_MD: begin
        r.md_start = 1;
        r.regw     = 1;
        r.wsel     = 2;
        r.cycles  += (mw + 1) + 1;
      end
      C_WB: begin
        r.regw   = 1;
        r.zout   = 1;
        r.wsel   = 0;
        r.cycles += 1;
      end
      C_BR: begin
        r.pc_ena += taken ? 1 : 0;
        r.pc_sel  = taken ? 1 : 0;
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [53:0] onebit(input int b);
    logic [53:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [53:0] class_bit(input int cls);
    case (cls)
      C_WB:    return onebit($urandom_range(0, 31));
      C_LD:    return onebit($urandom_range(32, 36));
      C_ST:    return onebit($urandom_range(37, 39));
      C_BR:    return onebit($urandom_range(40, 47));
      C_MD:    return onebit($urandom_range(48, 51));
      default: return onebit($urandom_range(52, 53));  // outside every class
    endcase
  endfunction

  // Primary class bit plus random bits of lower-priority classes.
  function automatic logic [53:0] make_instr(input int cls);
    logic [53:0] v;
    if (cls == C_NOP) begin
      v = ($urandom_range(0, 1) == 1) ? class_bit(C_NOP) : '0;
    end else begin
      v = class_bit(cls);
      for (int c = 1; c < cls; c++) begin
        if ($urandom_range(0, 2) == 0) v = v | class_bit(c);
      end
    end
    return v;
  endfunction

  // Drive one cycle of inputs. Inputs not consumed in the current state get
  // random values so that "ignored" behaviour is exercised.
  task automatic drive(input logic [53:0] ins, input logic taken,
                       inout int iw, inout int dw, inout int mw);
    logic [63:0] r64;
    r64           = {$urandom, $urandom};
    decoded_instr = r64[53:0];
    imem_ready    = 1'($urandom_range(0, 1));
    dmem_ready    = 1'($urandom_range(0, 1));
    md_done       = 1'($urandom_range(0, 1));
    branch_taken  = 1'($urandom_range(0, 1));
    if (state == S_IF) begin
      imem_ready = (iw == 0);
      if (iw > 0) iw--;
    end
    if (state == S_ID) decoded_instr = ins;
    if (state == S_EX) branch_taken = taken;
    if (state == S_MEM) begin
      dmem_ready = (dw == 0);
      if (dw > 0) dw--;
    end
    if (state == S_MD) begin
      md_done = (mw == 0);
      if (mw > 0) mw--;
    end
  endtask

  task automatic perf_check(input string tag);
`ifdef CTRL_PERF_EN
    chk({tag, "_cycle_cnt"}, cycle_cnt, tb_cyc % (1 << CW));
    chk({tag, "_retire_cnt"}, retire_cnt, tb_ret % (1 << CW));
`else
    chk({tag, "_cycle_cnt"}, cycle_cnt, 0);
    chk({tag, "_retire_cnt"}, retire_cnt, 0);
`endif
  endtask

  task automatic run_instr(input logic [53:0] ins, input int cls, input bit taken,
                           input int iw, input int dw, input int mw, input bit do_perf);
    int iwl, dwl, mwl, cyc;
    bit done;
    iwl = iw; dwl = dw; mwl = mw;
    exp_q.push_back(model(cls, taken, iw, dw, mw));
    done = 0;
    cyc  = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      drive(ins, taken, iwl, dwl, mwl);
      if (cyc == 1 && do_perf) perf_check("perf");
      #1;
      if (instr_done) done = 1;
    end
    if (!done) begin
      chk("instr_timeout", cyc, -1);
      summary();
      $finish;
    end
    tb_ret++;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state"}, state, S_IF);
    chk({tag, "_outputs"}, {ir_in, pc_ena, pc_sel, decode_ena, zin, zout, md_start,
                            dmem_rd, dmem_wr, regfile_w, rf_wsel, instr_done,
                            cycle_cnt, retire_cnt}, 0);
  endtask

  // Store stalled in MEM, reset dropped between clock edges in its 2nd MEM cycle.
  task automatic abort_store();
    int iwl, dwl, mwl, mem_cyc;
    iwl = 0; dwl = 10; mwl = 0; mem_cyc = 0;
    for (int i = 0; i < 30 && mem_cyc < 2; i++) begin
      @(negedge clk);
      drive(onebit(37), 1'b0, iwl, dwl, mwl);
      if (state == S_MEM) mem_cyc++;
    end
    chk("abort_reached_mem", mem_cyc, 2);
    #3;
    rst_ni = 1'b0;
    #1;
    check_zero("abort_now");
    dmem_ready = 1'b1;
    @(posedge clk);
    #1;
    check_zero("abort_hold");
    @(posedge clk);
    #2;
    rst_ni = 1'b1;
    tb_ret = 0;
    #1;
    chk("restart_state", state, S_IF);
  endtask

  // Monitor: accumulate per-cycle behaviour, compare on each retirement.
  always @(negedge clk) begin
    #2;
    if (!rst_ni) begin
      acc = '{default: 0};
    end else begin
      acc.cycles++;
      acc.ir_in    += int'(ir_in);
      acc.pc_ena   += int'(pc_ena);
      acc.pc_sel   += int'(pc_sel);
      acc.decode   += int'(decode_ena);
      acc.zin      += int'(zin);
      acc.zout     += int'(zout);
      acc.md_start += int'(md_start);
      acc.rd       += int'(dmem_rd);
      acc.wr       += int'(dmem_wr);
      acc.regw     += int'(regfile_w);
      if (regfile_w) acc.wsel = int'(rf_wsel);
      else if (rf_wsel != 2'd0) acc.wsel_bad++;
      if ($countones(state) != 1) chk("state_onehot", state, -1);
      if (instr_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_retire", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          n_ret++;
          chk("cycles",   acc.cycles,   mon_e.cycles);
          chk("ir_in",    acc.ir_in,    mon_e.ir_in);
          chk("pc_ena",   acc.pc_ena,   mon_e.pc_ena);
          chk("pc_sel",   acc.pc_sel,   mon_e.pc_sel);
          chk("decode",   acc.decode,   mon_e.decode);
          chk("zin",      acc.zin,      mon_e.zin);
          chk("zout",     acc.zout,     mon_e.zout);
          chk("md_start", acc.md_start, mon_e.md_start);
          chk("dmem_rd",  acc.rd,       mon_e.rd);
          chk("dmem_wr",  acc.wr,       mon_e.wr);
          chk("regw",     acc.regw,     mon_e.regw);
          chk("rf_wsel",  acc.wsel,     mon_e.wsel);
          chk("wsel_idle", acc.wsel_bad, 0);
          $display("retire %0d: cycles=%0d regw=%0d wsel=%0d rd=%0d wr=%0d",
                   n_ret, acc.cycles, acc.regw, acc.wsel, acc.rd, acc.wr);
        end
        acc = '{default: 0};
      end
    end
  end

  initial begin
    int cls, iw, dw, mw;
    bit tk;
    acc = '{default: 0};

    // Reset hold: outputs must stay quiet whatever the inputs do.
    imem_ready = 1'b1; dmem_ready = 1'b1; md_done = 1'b1; branch_taken = 1'b1;
    decoded_instr = onebit(0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_zero("reset");
    end
    @(posedge clk);
    #2;
    rst_ni = 1'b1;
    tb_ret = 0;

    // Directed cases.
    run_instr(onebit(0),  C_WB, 1'b0, 0, 0, 0, 1'b1);  // ALU op, 4 cycles
    run_instr(onebit(32), C_LD, 1'b0, 0, 2, 0, 1'b0);  // load, 7 cycles
    run_instr(onebit(40), C_BR, 1'b1, 0, 0, 0, 1'b0);  // branch taken
    run_instr(onebit(40), C_BR, 1'b0, 0, 0, 0, 1'b0);  // branch not taken
    run_instr(onebit(48), C_MD, 1'b0, 0, 0, 4, 1'b0);  // mul/div, 5 MD cycles
    run_instr(onebit(37), C_ST, 1'b0, 0, 0, 0, 1'b0);  // store, 4 cycles
    run_instr('0,         C_NOP, 1'b0, 0, 0, 0, 1'b0); // NOP, 3 cycles

    // Asynchronous reset in the middle of a store.
    abort_store();

    // 20 ALU ops back to back, then counters checked at the start of the 21st.
    for (int i = 0; i < 20; i++) run_instr(onebit(i), C_WB, 1'b0, 0, 0, 0, 1'b0);
    run_instr(onebit(5), C_WB, 1'b0, 0, 0, 0, 1'b1);

    // Randomised instruction stream with random stalls.
    for (int i = 0; i < 60; i++) begin
      cls = $urandom_range(0, 5);
      tk  = 1'($urandom_range(0, 1));
      iw  = $urandom_range(0, 3);
      dw  = $urandom_range(0, 3);
      mw  = $urandom_range(0, 6);
      run_instr(make_instr(cls), cls, tk, iw, dw, mw, (i == 59));
    end

    // Let the last retirement reach the monitor.
    @(negedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    summary();
    $finish;
  end

endmodule
